pipelined_adder: RTL and testbench

//   Parametrised, pipelined N_BIT adder with carry-in and carry-out.
//   The operands are split into CHUNK-bit slices, and one slice is added per pipeline stage.
//   The carry is registered between stages, so timing is bounded by a CHUNK-bit ripple.
//   A valid/ready stream handshake sits on both sides. The block is the arithmetic datapath

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 21 ++
 rtl/pipelined_adder.sv | 115 +++++++++++
 tb/tb_pipelined_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared helpers for the pipelined adder (stage count, config check)
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  function automatic int stages(input int n, input int c);
    return n / c;
  endfunction

  // A slice width must be positive, no wider than the word, and divide it evenly.
  function automatic bit chunk_ok(input int n, input int c);
    return (c > 0) && (n >= c) && ((n % c) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
// adder_chunk : combinational CHUNK-bit ripple adder slice (a + b + cin)
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder : N_BIT adder, one CHUNK slice per stage, valid/ready stream.
// Optional macro ADDER_OVF_EN adds a signed-overflow output. Rev 1.0
// ============================================================================
`default_nettype none

module pipelined_adder
  import adder_pkg::*;
#(
  parameter int N_BIT = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] sum,
  output logic             carry_out
`ifdef ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = stages(N_BIT, CHUNK);

  if (!chunk_ok(N_BIT, CHUNK)) begin : g_cfg_error
    $error("pipelined_adder: N_BIT must be a positive multiple of CHUNK");
  end

  logic                          advance;
  logic [STAGES-1:0]             vld;
  logic [STAGES-1:0]             cry;
  logic [STAGES-1:0]             v_src;
  logic [STAGES-1:0]             c_src;
  logic [STAGES-1:0]             chunk_c;
  logic [STAGES-1:0][N_BIT-1:0]  a_q;
  logic [STAGES-1:0][N_BIT-1:0]  b_q;
  logic [STAGES-1:0][N_BIT-1:0]  s_q;
  logic [STAGES-1:0][N_BIT-1:0]  a_src;
  logic [STAGES-1:0][N_BIT-1:0]  b_src;
  logic [STAGES-1:0][N_BIT-1:0]  s_src;
  logic [STAGES-1:0][N_BIT-1:0]  s_nxt;
  logic [STAGES-1:0][CHUNK-1:0]  chunk_s;

  // Whole pipeline moves as one; only a held result at the output can stall it.
  assign advance  = !vld[STAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_src[k] = in_valid;
      assign c_src[k] = carry_in;
      assign a_src[k] = a;
      assign b_src[k] = b;
      assign s_src[k] = '0;
    end else begin : g_link
      assign v_src[k] = vld[k-1];
      assign c_src[k] = cry[k-1];
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a    (a_src[k][k*CHUNK +: CHUNK]),
      .b    (b_src[k][k*CHUNK +: CHUNK]),
      .cin  (c_src[k]),
      .s    (chunk_s[k]),
      .cout (chunk_c[k])
    );

    // Slice k of the partial sum is still zero here, so OR merges the new slice in.
    assign s_nxt[k] = s_src[k] | (N_BIT'(chunk_s[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      cry <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (advance) begin
      vld <= v_src;
      cry <= chunk_c;
      a_q <= a_src;
      b_q <= b_src;
      s_q <= s_nxt;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = cry[STAGES-1];

`ifdef ADDER_OVF_EN
  // Last stage still holds the original operand MSBs alongside the finished sum.
  assign overflow = (a_q[STAGES-1][N_BIT-1] == b_q[STAGES-1][N_BIT-1]) &&
                    (s_q[STAGES-1][N_BIT-1] != a_q[STAGES-1][N_BIT-1]);
`endif

  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// tb_pipelined_adder : directed self-checking bench, 16/4 and 16/16 configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, carry_in;
  logic [15:0] a, b;
  logic        in_ready, out_valid, carry_out;
  logic [15:0] sum;
`ifdef ADDER_OVF_EN
  logic        overflow, s_overflow;
`endif

  logic        s_in_valid, s_out_ready, s_carry_in;
  logic [15:0] s_a, s_b;
  logic        s_in_ready, s_out_valid, s_carry_out;
  logic [15:0] s_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.N_BIT(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  pipelined_adder #(.N_BIT(16), .CHUNK(16)) dut_one (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .a         (s_a),
    .b         (s_b),
    .carry_in  (s_carry_in),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .sum       (s_sum),
    .carry_out (s_carry_out)
`ifdef ADDER_OVF_EN
    ,
    .overflow  (s_overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat through the 4-stage DUT; returns with the result emitted.
  task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    a = va; b = vb; carry_in = vc; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  32'(lat), 32'd4);
    check({tag, "_sum"},  32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(carry_out), 32'(exp_cout));
    tick();
  endtask

  initial begin
    logic [16:0] q[$];
    logic [16:0] exp_v;
    int sent, got_n, ready_drop, gaps, emit_n, stale, lat;
    logic [15:0] ra, rb;
    logic rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; carry_in = 1'b0; a = '0; b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_carry_in = 1'b0; s_a = '0; s_b = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(carry_out), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    run_one("wrap1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_one("wrapcin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_one("plain",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_one("xchunk",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_one("msbs",    16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    run_one("ripple",  16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

`ifdef ADDER_OVF_EN
    a = 16'h7FFF; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0; tick(); tick(); tick();
    check("ovf_pos_sum", 32'(sum), 32'h8000);
    check("ovf_pos_ovf", 32'(overflow), 32'd1);
    tick();
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    tick(); in_valid = 1'b0; tick(); tick(); tick();
    check("ovf_neg_sum",  32'(sum), 32'hFFFE);
    check("ovf_neg_cout", 32'(carry_out), 32'd1);
    check("ovf_neg_ovf",  32'(overflow), 32'd0);
    tick();
`endif

    // 100 back-to-back beats against the a+b+cin scoreboard.
    sent = 0; got_n = 0; ready_drop = 0; gaps = 0;
    for (int cyc = 0; cyc < 200 && got_n < 100; cyc++) begin
      if (sent < 100) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        a = ra; b = rb; carry_in = rc; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 17'h1_FFFF;
        check("stream_beat", 32'({carry_out, sum}), 32'(exp_v));
        got_n++;
      end else if (got_n > 0) begin
        gaps++;
      end
      if (in_valid) begin
        if (!in_ready) ready_drop++;
        else begin
          q.push_back({1'b0, a} + {1'b0, b} + {16'd0, carry_in});
          sent++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got_n), 32'd100);
    check("stream_ready", 32'(ready_drop), 32'd0);
    check("stream_gaps",  32'(gaps), 32'd0);
    tick(); tick();

    // Output stall: result must hold and be emitted exactly once.
    a = 16'h1234; b = 16'h0FF0; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("stall_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("stall_sum",   32'(sum), 32'h2224);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    emit_n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid && out_ready) emit_n++;
      tick();
    end
    check("stall_emit_once", 32'(emit_n), 32'd1);

    // Fill pipeline, then reset for one cycle.
    for (int i = 0; i < 4; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0101; carry_in = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("full_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",   32'(sum), 32'd0);
    check("midrst_cout",  32'(carry_out), 32'd0);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("midrst_stale", 32'(stale), 32'd0);

    // Single-stage configuration.
    s_a = 16'h00FF; s_b = 16'h0F01; s_carry_in = 1'b1; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("one_lat",  32'(lat), 32'd1);
    check("one_sum",  32'(s_sum), 32'h1001);
    check("one_cout", 32'(s_carry_out), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
